// File: rtl/mips_mdu.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over 32 RUN cycles, with architectural HI/LO registers and MTHI/MTLO moves.
module mips_mdu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  state_dbg
);

  // Handshake: start is taken on any edge where busy=0; operands are sampled only
  // then, and done pulses for exactly one cycle when HI/LO carry the new result.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] acc_hi_q, acc_lo_q, opnd_q, srca_q;
  logic        is_div_q, res_neg_q, rem_neg_q, div0_q;

  logic        accept;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_trial;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod, prod_fix;
  logic [31:0] q_fix, r_fix, res_hi, res_lo;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == 5'd31) state_d = FINISH;
      FINISH:  state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Signed ops (MULT, DIV) have op[0]=0 and run on operand magnitudes.
  always_comb begin
    accept = start && (state_q != RUN);
    a_neg  = ~op[0] & srca[31];
    b_neg  = ~op[0] & srcb[31];
    a_mag  = a_neg ? (~srca + 32'd1) : srca;
    b_mag  = b_neg ? (~srcb + 32'd1) : srcb;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : 32'd0)};
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_trial = div_shift - {1'b0, opnd_q};
    step_hi   = mul_sum[32:1];
    step_lo   = {mul_sum[0], acc_lo_q[31:1]};
    if (is_div_q) begin
      if (!div_trial[32]) begin
        step_hi = div_trial[31:0];
        step_lo = {acc_lo_q[30:0], 1'b1};
      end else begin
        step_hi = div_shift[31:0];
        step_lo = {acc_lo_q[30:0], 1'b0};
      end
    end
  end

  // Sign correction of the last iteration's result; a zero divisor bypasses it.
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = res_neg_q ? (~prod + 64'd1) : prod;
    q_fix    = res_neg_q ? (~step_lo + 32'd1) : step_lo;
    r_fix    = rem_neg_q ? (~step_hi + 32'd1) : step_hi;
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (is_div_q) begin
      if (div0_q) begin
        res_hi = srca_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = r_fix;
        res_lo = q_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      opnd_q    <= 32'd0;
      srca_q    <= 32'd0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q     <= 5'd0;
        acc_hi_q  <= 32'd0;
        acc_lo_q  <= op[1] ? a_mag : b_mag;
        opnd_q    <= op[1] ? b_mag : a_mag;
        srca_q    <= srca;
        is_div_q  <= op[1];
        res_neg_q <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
        div0_q    <= (srcb == 32'd0);
      end else if (state_q == RUN) begin
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
        cnt_q    <= cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      end else begin
        if (mthi) hi_q <= srca;
        if (mtlo) lo_q <= srca;
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == FINISH);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule
